camera_pixel_unpack: RTL and testbench



---
 rtl/camera_pkg.sv | 23 ++
 rtl/camera_pix_pos_cnt.sv | 55 +++++
 rtl/camera_pixel_unpack.sv | 151 +++++++++++++++
 tb/tb_camera_pixel_unpack.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/camera_pkg.sv
// -----------------------------------------------------------------------------
// camera_pkg
// Shared types and constants for the camera read-side pixel path.
//   CAM_XY_W            width of the column/row position counters
//   cam_pix_flags_t     per-pixel frame markers {sof, eol, eof}
//   cam_unpack_state_t  word holding state of the unpacker
// -----------------------------------------------------------------------------
package camera_pkg;

    localparam int CAM_XY_W = 12;

    typedef struct packed {
        logic sof;
        logic eol;
        logic eof;
    } cam_pix_flags_t;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_HOLD  = 1'b1
    } cam_unpack_state_t;

endpackage

// File: rtl/camera_pix_pos_cnt.sv
// -----------------------------------------------------------------------------
// camera_pix_pos_cnt
// Column/row position of the pixel currently offered downstream, plus the
// unqualified frame markers decoded from that position.
//   rd_clk, rd_rst   clock, asynchronous active-high reset
//   advance          a pixel transferred this cycle; step the position
//   frame_sync       restart at x=0, y=0 (wins over advance)
//   h_act, v_act     active pixels per line / active lines per frame
//   x_cnt, y_cnt     current column / row
//   flags            sof/eol/eof decoded from x_cnt/y_cnt (not valid-gated)
// -----------------------------------------------------------------------------
module camera_pix_pos_cnt
    import camera_pkg::*;
(
    input  logic                rd_clk,
    input  logic                rd_rst,
    input  logic                advance,
    input  logic                frame_sync,
    input  logic [CAM_XY_W-1:0] h_act,
    input  logic [CAM_XY_W-1:0] v_act,
    output logic [CAM_XY_W-1:0] x_cnt,
    output logic [CAM_XY_W-1:0] y_cnt,
    output cam_pix_flags_t      flags
);

    logic x_last;
    logic y_last;

    assign x_last = (x_cnt == h_act - CAM_XY_W'(1));
    assign y_last = (y_cnt == v_act - CAM_XY_W'(1));

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            x_cnt <= '0;
            y_cnt <= '0;
        end else if (frame_sync) begin
            x_cnt <= '0;
            y_cnt <= '0;
        end else if (advance) begin
            if (x_last) begin
                x_cnt <= '0;
                y_cnt <= y_last ? '0 : y_cnt + CAM_XY_W'(1);
            end else begin
                x_cnt <= x_cnt + CAM_XY_W'(1);
            end
        end
    end

    assign flags.sof = (x_cnt == '0) && (y_cnt == '0);
    assign flags.eol = x_last;
    assign flags.eof = x_last && y_last;

endmodule

// File: rtl/camera_pixel_unpack.sv
// -----------------------------------------------------------------------------
// camera_pixel_unpack
// Pops packed words from the prefetch FIFO read port and emits their pixels,
// least-significant lane first, one per cycle on a valid/ready stream with
// sof/eol/eof markers derived from the pixel position.
//   rd_clk, rd_rst        clock, asynchronous active-high reset
//   frame_sync            restart: drop the held word, position back to 0,0
//   fifo_rd_data/_vld     FIFO word and its valid
//   fifo_rd_en            pop request (word taken on fifo_rd_vld & fifo_rd_en)
//   pix_data/_vld/_rdy    pixel stream (transfer on pix_vld & pix_rdy)
//   pix_sof/_eol/_eof     markers of the pixel on pix_data
//   x_cnt, y_cnt          position of the pixel on pix_data
//   frame_cnt             completed frames
// Build option CAMERA_UNPACK_FRAME_CNT_EN: when defined, frame_cnt counts
// transfers of eof pixels (cleared only by rd_rst); otherwise it is tied to 0.
// -----------------------------------------------------------------------------
module camera_pixel_unpack
    import camera_pkg::*;
#(
    parameter int IN_W  = 32,
    parameter int PIX_W = 16,
    parameter int RATIO = 2,
    parameter int H_ACT = 1280,
    parameter int V_ACT = 720
) (
    input  logic                rd_clk,
    input  logic                rd_rst,
    input  logic                frame_sync,
    input  logic [IN_W-1:0]     fifo_rd_data,
    input  logic                fifo_rd_vld,
    output logic                fifo_rd_en,
    output logic [PIX_W-1:0]    pix_data,
    output logic                pix_vld,
    input  logic                pix_rdy,
    output logic                pix_sof,
    output logic                pix_eol,
    output logic                pix_eof,
    output logic [CAM_XY_W-1:0] x_cnt,
    output logic [CAM_XY_W-1:0] y_cnt,
    output logic [15:0]         frame_cnt
);

    // A single-lane build still needs a 1-bit lane index to stay legal.
    localparam int                LANE_W    = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(RATIO - 1);

    cam_unpack_state_t state_q, state_d;
    logic [IN_W-1:0]   word_q,  word_d;
    logic [LANE_W-1:0] lane_q,  lane_d;

    logic           hold_q;
    logic           last_lane;
    logic           accept;
    logic           transfer;
    cam_pix_flags_t pos_flags;

    assign hold_q    = (state_q == ST_HOLD);
    assign last_lane = (lane_q == LANE_LAST);

    // Pop when empty, or when the last lane leaves this cycle so the next
    // word lands without a bubble. frame_sync blocks the pop outright.
    assign fifo_rd_en = ~frame_sync & (~hold_q | (pix_rdy & last_lane));
    assign accept     = fifo_rd_vld & fifo_rd_en;
    assign transfer   = pix_vld & pix_rdy & ~frame_sync;

    assign pix_vld  = hold_q;
    assign pix_data = word_q[int'(lane_q) * PIX_W +: PIX_W];

    // NOTE: defaults first so every path assigns every next-state signal;
    // a missing branch would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        lane_d  = lane_q;
        if (frame_sync) begin
            state_d = ST_EMPTY;
            lane_d  = '0;
        end else begin
            unique case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        state_d = ST_HOLD;
                        word_d  = fifo_rd_data;
                        lane_d  = '0;
                    end
                end
                ST_HOLD: begin
                    if (transfer) begin
                        if (!last_lane) begin
                            lane_d = lane_q + LANE_W'(1);
                        end else if (accept) begin
                            word_d = fifo_rd_data;
                            lane_d = '0;
                        end else begin
                            state_d = ST_EMPTY;
                            lane_d  = '0;
                        end
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    // NOTE: the holding register is reset with the control state so pix_data
    // reads 0 out of reset instead of whatever the flops powered up to.
    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            state_q <= ST_EMPTY;
            word_q  <= '0;
            lane_q  <= '0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            lane_q  <= lane_d;
        end
    end

    camera_pix_pos_cnt u_pos_cnt (
        .rd_clk     (rd_clk),
        .rd_rst     (rd_rst),
        .advance    (transfer),
        .frame_sync (frame_sync),
        .h_act      (CAM_XY_W'(H_ACT)),
        .v_act      (CAM_XY_W'(V_ACT)),
        .x_cnt      (x_cnt),
        .y_cnt      (y_cnt),
        .flags      (pos_flags)
    );

    assign pix_sof = pix_vld & pos_flags.sof;
    assign pix_eol = pix_vld & pos_flags.eol;
    assign pix_eof = pix_vld & pos_flags.eof;

`ifdef CAMERA_UNPACK_FRAME_CNT_EN
    logic [15:0] frame_cnt_q;

    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            frame_cnt_q <= '0;
        end else if (transfer && pix_eof) begin
            frame_cnt_q <= frame_cnt_q + 16'd1;
        end
    end

    assign frame_cnt = frame_cnt_q;
`else
    assign frame_cnt = '0;
`endif

endmodule

// File: tb/tb_camera_pixel_unpack.sv
// -----------------------------------------------------------------------------
// tb_camera_pixel_unpack
// Scoreboard bench for camera_pixel_unpack (H_ACT=4, V_ACT=2, RATIO=2).
// A FIFO model feeds words; every accepted word pushes its pixels into an
// expected queue, and a negedge monitor compares the stream, markers,
// position and pop request against a position/frame model.
// -----------------------------------------------------------------------------
module tb_camera_pixel_unpack;

    localparam int PIX_W = 16;
    localparam int RATIO = 2;
    localparam int IN_W  = PIX_W * RATIO;
    localparam int H_ACT = 4;
    localparam int V_ACT = 2;

    logic             rd_clk = 1'b0;
    logic             rd_rst;
    logic             frame_sync;
    logic [IN_W-1:0]  fifo_rd_data;
    logic             fifo_rd_vld;
    logic             fifo_rd_en;
    logic [PIX_W-1:0] pix_data;
    logic             pix_vld;
    logic             pix_rdy;
    logic             pix_sof;
    logic             pix_eol;
    logic             pix_eof;
    logic [11:0]      x_cnt;
    logic [11:0]      y_cnt;
    logic [15:0]      frame_cnt;

    camera_pixel_unpack #(
        .IN_W  (IN_W),
        .PIX_W (PIX_W),
        .RATIO (RATIO),
        .H_ACT (H_ACT),
        .V_ACT (V_ACT)
    ) dut (
        .rd_clk       (rd_clk),
        .rd_rst       (rd_rst),
        .frame_sync   (frame_sync),
        .fifo_rd_data (fifo_rd_data),
        .fifo_rd_vld  (fifo_rd_vld),
        .fifo_rd_en   (fifo_rd_en),
        .pix_data     (pix_data),
        .pix_vld      (pix_vld),
        .pix_rdy      (pix_rdy),
        .pix_sof      (pix_sof),
        .pix_eol      (pix_eol),
        .pix_eof      (pix_eof),
        .x_cnt        (x_cnt),
        .y_cnt        (y_cnt),
        .frame_cnt    (frame_cnt)
    );

    always #5 rd_clk = ~rd_clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        else
            n_pass++;
    endtask

    // ---------------- FIFO model (source) ----------------
    logic [IN_W-1:0]  src_q[$];
    logic             stall = 1'b0;
    logic             acc_seen = 1'b0;

    always @(negedge rd_clk)
        acc_seen = fifo_rd_vld && fifo_rd_en && !rd_rst;

    always begin
        @(posedge rd_clk);
        if (acc_seen && src_q.size() != 0) void'(src_q.pop_front());
        #2;
        fifo_rd_vld  = !stall && (src_q.size() != 0);
        fifo_rd_data = (src_q.size() != 0) ? src_q[0] : '0;
    end

    // ---------------- reference model + monitor ----------------
    logic [PIX_W-1:0] exp_q[$];
    int               mx = 0;
    int               my = 0;
    logic [15:0]      frames = '0;
    int               n_exp;
    logic             e_sof, e_eol, e_eof;
    logic [15:0]      e_fcnt;

    always @(negedge rd_clk) begin
        if (rd_rst) begin
            exp_q.delete();
            mx     = 0;
            my     = 0;
            frames = '0;
        end else begin
            n_exp = exp_q.size();
            // Pop needed when nothing is held, or the final held pixel leaves now.
            check("fifo_rd_en", fifo_rd_en,
                  !frame_sync && (n_exp == 0 || (n_exp == 1 && pix_rdy)));
            check("pix_vld", pix_vld, n_exp != 0);
            e_sof = (n_exp != 0) && mx == 0 && my == 0;
            e_eol = (n_exp != 0) && mx == H_ACT - 1;
            e_eof = e_eol && my == V_ACT - 1;
            check("pix_sof", pix_sof, e_sof);
            check("pix_eol", pix_eol, e_eol);
            check("pix_eof", pix_eof, e_eof);
            if (n_exp != 0) begin
                check("pix_data", pix_data, exp_q[0]);
                check("x_cnt", x_cnt, mx);
                check("y_cnt", y_cnt, my);
            end
`ifdef CAMERA_UNPACK_FRAME_CNT_EN
            e_fcnt = frames;
`else
            e_fcnt = '0;
`endif
            check("frame_cnt", frame_cnt, e_fcnt);

            if (frame_sync) begin
                exp_q.delete();
                mx = 0;
                my = 0;
            end else begin
                if (pix_vld && pix_rdy && n_exp != 0) begin
                    void'(exp_q.pop_front());
                    if (mx == H_ACT - 1 && my == V_ACT - 1) frames = frames + 16'd1;
                    if (mx == H_ACT - 1) begin
                        mx = 0;
                        my = (my == V_ACT - 1) ? 0 : my + 1;
                    end else begin
                        mx = mx + 1;
                    end
                end
                if (fifo_rd_vld && fifo_rd_en)
                    for (int i = 0; i < RATIO; i++)
                        exp_q.push_back(fifo_rd_data[i*PIX_W +: PIX_W]);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic check_reset();
        check("rst_pix_vld", pix_vld, 0);
        check("rst_pix_data", pix_data, 0);
        check("rst_sof", pix_sof, 0);
        check("rst_eol", pix_eol, 0);
        check("rst_eof", pix_eof, 0);
        check("rst_x_cnt", x_cnt, 0);
        check("rst_y_cnt", y_cnt, 0);
        check("rst_frame_cnt", frame_cnt, 0);
        check("rst_fifo_rd_en", fifo_rd_en, 1);
    endtask

    task automatic wait_drain(input int max_cycles);
        bit done = 0;
        pix_rdy = 1'b1;
        stall   = 1'b0;
        for (int i = 0; i < max_cycles && !done; i++) begin
            @(posedge rd_clk); #1;
            done = (src_q.size() == 0) && (exp_q.size() == 0);
        end
        check("drain_done", done, 1);
    endtask

    task automatic pulse_reset();
        @(posedge rd_clk); #3;
        rd_rst = 1'b1;
        #1;
        check_reset();
        @(posedge rd_clk); #3;
        rd_rst = 1'b0;
    endtask

    logic [3:0] rdy_pat;
    bit         hit;

    initial begin
        rd_rst       = 1'b1;
        frame_sync   = 1'b0;
        pix_rdy      = 1'b0;
        fifo_rd_vld  = 1'b0;
        fifo_rd_data = '0;
        repeat (2) @(posedge rd_clk);
        #1;
        check_reset();
        #2;
        rd_rst = 1'b0;

        // Nominal stream: one full 4x2 frame, one pixel per cycle.
        pix_rdy = 1'b1;
        for (int k = 0; k < 4; k++)
            src_q.push_back({16'(2*k + 2), 16'(2*k + 1)});
        wait_drain(100);

        // Backpressure: lane 0 held across stalled cycles, then lane 1.
        pix_rdy = 1'b0;
        src_q.push_back(32'hBBBB_AAAA);
        hit = 0;
        for (int i = 0; i < 20 && !hit; i++) begin
            @(posedge rd_clk); #1;
            hit = pix_vld;
        end
        check("bp_vld_seen", hit, 1);
        rdy_pat = 4'b1100;  // applied LSB first: 0,0,1,1
        for (int i = 0; i < 4; i++) begin
            pix_rdy = rdy_pat[i];
            @(posedge rd_clk); #1;
        end
        wait_drain(50);

        // Underrun mid-line (next pixel is x=2): stream stalls, no marker.
        stall = 1'b1;
        src_q.push_back(32'h2222_1111);
        src_q.push_back(32'h4444_3333);
        repeat (5) @(posedge rd_clk);
        #1;
        wait_drain(50);

        // frame_sync while lane 0 of x=2, y=1 is held.
        src_q.push_back(32'h5A5A_A5A5);
        src_q.push_back(32'h0BAD_F00D);
        src_q.push_back(32'h1234_5678);
        pix_rdy = 1'b1;
        hit = 0;
        for (int i = 0; i < 50 && !hit; i++) begin
            @(posedge rd_clk); #1;
            if (mx == 2 && my == 1 && exp_q.size() == 2 && pix_vld) begin
                hit = 1;
                frame_sync = 1'b1;
                @(posedge rd_clk); #1;
                frame_sync = 1'b0;
            end
        end
        check("fsync_point_hit", hit, 1);
        wait_drain(50);

        // Randomised traffic: backpressure, underruns, sporadic frame_sync.
        for (int i = 0; i < 800; i++) begin
            @(posedge rd_clk); #1;
            pix_rdy    = ($urandom_range(0, 3) != 0);
            stall      = ($urandom_range(0, 4) == 0);
            frame_sync = ($urandom_range(0, 59) == 0);
            if (src_q.size() < 4) src_q.push_back($urandom);
        end
        frame_sync = 1'b0;
        wait_drain(100);

        // Async reset mid-line drops the held word; restart tagged sof.
        pix_rdy = 1'b1;
        for (int k = 0; k < 3; k++) src_q.push_back($urandom);
        @(posedge rd_clk);
        pulse_reset();
        wait_drain(50);

        // Three complete frames from a clean reset.
        pulse_reset();
        for (int k = 0; k < 3 * H_ACT * V_ACT / RATIO; k++) src_q.push_back($urandom);
        wait_drain(200);
`ifdef CAMERA_UNPACK_FRAME_CNT_EN
        check("frame_cnt_3", frame_cnt, 3);
`else
        check("frame_cnt_tied", frame_cnt, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
